// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the arbiter and uart_tx.
// The slave modport is the arbiter's view. The master modport is the requester/UART side.
interface uart_tx_arbiter_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0]   req_valid;
    logic [8*N_CH-1:0] req_data;
    logic [N_CH-1:0]   req_last;
    logic [N_CH-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_ready;
    logic [N_CH-1:0]   grant;
    logic              busy;
    logic              trunc;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_start, grant, busy, trunc
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_start, grant, busy, trunc
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler for one uart_tx shared by N_CH byte streams. Each grant sends a
// channel header byte, then up to MAX_BURST payload bytes from the granted channel.
module uart_tx_arbiter #(
    parameter int         N_CH      = 2,
    parameter logic [7:0] HDR_BASE  = 8'hA0,
    parameter int         MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWAIT, S_DATA, S_DWAIT} state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [1:0]      gidx;
    logic [7:0]      cnt;
    logic            last_seen;
    logic [N_CH-1:0] grant_q;
    logic            busy_q;
    logic            trunc_q;

    // Requester vectors are widened to four lanes so a 2-bit channel index is always in range.
    logic [3:0]      valid_pad;
    logic [3:0]      last_pad;
    logic [31:0]     data_pad;

    logic            pick_valid;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic [1:0]      ptr_next;
    logic            tx_start_c;
    logic [7:0]      tx_data_c;
    logic [N_CH-1:0] ready_c;

    assign valid_pad = 4'(bus.req_valid);
    assign last_pad  = 4'(bus.req_last);
    assign data_pad  = 32'(bus.req_data);
    assign ptr_next  = (gidx == 2'(N_CH - 1)) ? 2'd0 : gidx + 2'd1;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = 2'd0;
        // Scan from the far end so the requester closest after ptr is the last one to win.
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = 2'((int'(ptr) + k) % N_CH);
            if (valid_pad[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The launch strobe and requester ready stay combinational, so a byte moves in the cycle uart_tx is idle.
    always_comb begin
        tx_start_c = 1'b0;
        tx_data_c  = 8'h00;
        ready_c    = '0;
        if (!rst) begin
            case (state)
                S_HDR: begin
                    tx_start_c = bus.tx_ready;
                    tx_data_c  = HDR_BASE | {6'b000000, gidx};
                end
                S_DATA: begin
                    tx_start_c = valid_pad[gidx] & bus.tx_ready;
                    tx_data_c  = data_pad[{gidx, 3'b000} +: 8];
                    ready_c    = N_CH'({3'b000, tx_start_c} << gidx);
                end
                default: begin
                    tx_start_c = 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = tx_data_c;
    assign bus.req_ready = ready_c;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.trunc     = trunc_q;

    // NOTE: state is updated with <= so every register sees the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= 2'd0;
            gidx      <= 2'd0;
            cnt       <= 8'd0;
            last_seen <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            trunc_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gidx      <= pick_idx;
                        grant_q   <= N_CH'(4'b0001 << pick_idx);
                        cnt       <= 8'd0;
                        last_seen <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (tx_start_c) state <= S_HWAIT;
                end
                S_HWAIT: begin
                    if (bus.tx_ready) state <= S_DATA;
                end
                S_DATA: begin
                    if (tx_start_c) begin
                        cnt       <= cnt + 8'd1;
                        last_seen <= last_pad[gidx];
                        state     <= S_DWAIT;
                    end
                end
                S_DWAIT: begin
                    if (bus.tx_ready) begin
                        if (last_seen || cnt == 8'(MAX_BURST)) begin
                            // A message ending exactly on the limit is a normal end, not a truncation.
                            trunc_q <= !last_seen;
                            ptr     <= ptr_next;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among up to four byte-stream requesters, such as the key-event message source and status reporters. On each grant it sends one header byte identifying the channel, then streams that channel's payload bytes until the channel marks the last byte or a burst limit is reached. It sits between the requesters and `uart_tx` and sequences `uart_tx` through a start/ready handshake.

## Interface
Parameters:
- `N_CH`, 2: number of requesters, 1..4.
- `HDR_BASE`, 8'hA0: header byte is `HDR_BASE | ch` (channel index in bits [1:0]).
- `MAX_BURST`, 16: maximum payload bytes per grant, 1..255.

Ports:
- `clk`  in  1  system clock (50 MHz on board).
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_CH  per-channel byte available.
- `req_data`  in  8*N_CH  per-channel byte; channel i occupies [8i+7:8i].
- `req_last`  in  N_CH  qualifies `req_data` as the final byte of the message.
- `req_ready`  out  N_CH  byte accepted this cycle (combinational).
- `tx_data`  out  8  byte to `uart_tx`, valid while `tx_start`=1.
- `tx_start`  out  1  one-cycle launch strobe to `uart_tx` (combinational).
- `tx_ready`  in  1  `uart_tx` idle. Contract: it drops in the cycle after a sampled `tx_start` and rises when the stop bit ends.
- `grant`  out  N_CH  registered, one-hot; the current owner, all zero when idle.
- `busy`  out  1  registered; high in every state except IDLE.
- `trunc`  out  1  registered; one-cycle pulse when a burst ends on `MAX_BURST` without `req_last`.

## Operation
State machine states: IDLE, HDR, HWAIT, DATA, DWAIT. Registers: `state`, `ptr` (round-robin start index), `gidx`, `cnt` (8 bit), `last_seen`.

- **IDLE**
  - If any `req_valid` is set, select the first set channel scanning `ptr`, `ptr+1`, … modulo `N_CH`.
  - Load `gidx`, `grant`=onehot(`gidx`), `cnt`=0, `last_seen`=0, then go to HDR.
- **HDR**
  - `tx_start` = `tx_ready`, `tx_data` = `HDR_BASE | gidx`.
  - When `tx_start`=1, go to HWAIT.
- **HWAIT**
  - When `tx_ready`=1, go to DATA.
  - The first cycle always sees `tx_ready`=0, per the `uart_tx` contract.
- **DATA**
  - `tx_start` = `req_ready[gidx]` = `req_valid[gidx] & tx_ready`, and `tx_data` = `req_data[gidx]`.
  - On a transfer: `cnt` += 1, `last_seen` = `req_last[gidx]`, go to DWAIT.
  - If the owner drops `req_valid`, the FSM stays in DATA indefinitely with the grant held. There is no timeout.
- **DWAIT**, when `tx_ready`=1:
  - If `last_seen`: go to IDLE.
  - Else if `cnt`==`MAX_BURST`: go to IDLE and pulse `trunc`.
  - Else: go to DATA.
  - When exiting to IDLE: `ptr` = (`gidx`+1) mod `N_CH`, and `grant` clears.
- `req_ready` of non-granted channels is always 0. The header byte consumes no requester data.
- Requester rule: `req_data`/`req_last` must hold while `req_valid`=1 and `req_ready`=0.
- `req_valid` from other channels during a burst has no effect until the burst ends.

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `gidx`=0, `cnt`=0, `grant`=0, `busy`=0, `trunc`=0. With `rst`=1, `tx_start`=0, `req_ready`=0, `tx_data`=0.
- Reset mid-burst: the burst is abandoned; next cycle is IDLE with `ptr`=0. A UART frame already launched completes under `uart_tx` control. No requester byte is consumed in a reset cycle.
- Latency: `req_valid` is sampled in IDLE at cycle 0; `grant`/`busy` are high at cycle 1; the header `tx_start` is at cycle 1 if `tx_ready`=1.
- Per payload byte: one frame time plus 2 cycles of overhead (DATA→DWAIT, DWAIT→DATA).
- Between bursts: IDLE costs 1 cycle. The next header can launch 2 cycles after the last frame's `tx_ready` rise.
- `trunc` is asserted in the cycle after the DWAIT→IDLE transition, for exactly 1 cycle.
- `cnt` never exceeds `MAX_BURST`.
- `last_seen` and the limit both met: treated as normal end, no `trunc`.

## Test plan
- **Single burst:** `N_CH`=2, ch0 sends 0x55 then 0x31 (last). Expect UART bytes A0, 55, 31; `grant`=01 throughout; `busy` falls 1 cycle after the final `tx_ready` rise; `trunc`=0.
- **Simultaneous requests after reset:** ch0 and ch1 each send one byte (0x11 last, 0x22 last). Expect the order A0, 11, A1, 22; `ptr` ends at 0.
- **Round-robin fairness:** ch0 re-requests continuously, ch1 sends 3 one-byte messages. Expect bursts to alternate ch0/ch1; ch1 is never skipped.
- **Truncation:** `MAX_BURST`=4, ch1 sends 6 bytes 0x01..0x06 with `req_last` only on 0x06. Expect A1, 01..04, a `trunc` pulse, then A1, 05, 06 (assuming ch0 idle).
- **Back-pressure:** hold `tx_ready`=0 for 1000 cycles while in DATA with ch0 valid. Expect `tx_start`=0 and `req_ready`=0 throughout, and `tx_data`=`req_data[0]` stable. The transfer occurs on the first cycle `tx_ready`=1.
- **Reset mid-burst:** assert `rst` in DWAIT of ch0. Next cycle expect all outputs 0 and `ptr`=0. A following ch1 request emits A1 first.
